// File: rtl/hid_uart_tx_sched_if.sv
// Byte-stream requester bus and UART start/busy handshake shared by
// hid_uart_tx_sched (master side) and the requesters/UART (slave side).
interface hid_uart_tx_sched_if #(
  parameter int NREQ = 2
);
  logic [NREQ-1:0]   req_valid;
  logic [8*NREQ-1:0] req_data;
  logic [NREQ-1:0]   req_last;
  logic [NREQ-1:0]   req_ready;
  logic              uart_rts;
  logic              is_trans;
  logic              transmit;
  logic [7:0]        tx_byte;

  modport master (
    input  req_valid, req_data, req_last, uart_rts, is_trans,
    output req_ready, transmit, tx_byte
  );

  modport slave (
    output req_valid, req_data, req_last, uart_rts, is_trans,
    input  req_ready, transmit, tx_byte
  );
endinterface

// File: rtl/hid_uart_tx_sched.sv
// Shares one HID UART transmitter between NREQ byte-stream requesters.
// Round-robin grant with packet lock until 'last', uart_rts flow control,
// optional inter-byte gap and a watchdog that breaks stalled packets.
module hid_uart_tx_sched #(
  parameter int NREQ       = 2,
  parameter int GAP_CYCLES = 0,
  parameter int TIMEOUT    = 65535
) (
  input  logic                clk_i,
  input  logic                rst,
  hid_uart_tx_sched_if.master bus,
  output logic [2:0]          grant_idx,
  output logic                locked,
  output logic                busy,
  output logic                timeout_err
);

  localparam int              GW        = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
  localparam logic [GW-1:0]   GAP_LOAD  = GW'(GAP_CYCLES);
  localparam logic [GW-1:0]   GAP_ONE   = GW'(1);
  localparam logic [16:0]     WDOG_LAST = 17'(TIMEOUT - 1);
  localparam logic [2:0]      GRANT_RST = 3'(NREQ - 1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SEL   = 3'd1,
    ST_START = 3'd2,
    ST_ARM   = 3'd3,
    ST_BUSY  = 3'd4,
    ST_GAP   = 3'd5
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [2:0]      r_sel;
  logic [2:0]      r_grant_idx;
  logic            r_locked;
  logic [7:0]      r_tx_byte;
  logic            r_transmit;
  logic            r_timeout_err;
  logic            r_busy;
  logic            r_arm_cnt;
  logic [16:0]     r_wdog;
  logic [GW-1:0]   r_gap_cnt;

  logic            w_sel_valid;
  logic            w_sel_last;
  logic [7:0]      w_sel_data;
  logic [2:0]      w_pick_hi;
  logic            w_hit_hi;
  logic [2:0]      w_pick_lo;
  logic [2:0]      w_pick;
  logic [NREQ-1:0] w_ready;
  logic            w_accept;
  logic            w_stall;
  logic            w_expire;
  state_t          w_after_byte;

  // Mux out the valid/last/data of the requester currently selected.
  always_comb begin
    w_sel_valid = 1'b0;
    w_sel_last  = 1'b0;
    w_sel_data  = 8'h00;
    for (int i = 0; i < NREQ; i++) begin
      w_sel_valid = (r_sel == 3'(i)) ? bus.req_valid[i]      : w_sel_valid;
      w_sel_last  = (r_sel == 3'(i)) ? bus.req_last[i]       : w_sel_last;
      w_sel_data  = (r_sel == 3'(i)) ? bus.req_data[8*i +: 8] : w_sel_data;
    end
  end

  // Round-robin pick: lowest valid index above the last grant, else lowest valid overall.
  always_comb begin
    w_pick_hi = 3'd0;
    w_hit_hi  = 1'b0;
    w_pick_lo = 3'd0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      w_pick_hi = (bus.req_valid[i] && (3'(i) >  r_grant_idx)) ? 3'(i) : w_pick_hi;
      w_hit_hi  = (bus.req_valid[i] && (3'(i) >  r_grant_idx)) ? 1'b1  : w_hit_hi;
      w_pick_lo = (bus.req_valid[i] && (3'(i) <= r_grant_idx)) ? 3'(i) : w_pick_lo;
    end
    w_pick = w_hit_hi ? w_pick_hi : w_pick_lo;
  end

  // One-hot ready toward the selected requester; combinational on rts and its valid.
  always_comb begin
    w_ready = '0;
    for (int i = 0; i < NREQ; i++) begin
      w_ready[i] = (r_state == ST_SEL) && !bus.uart_rts && (r_sel == 3'(i)) && bus.req_valid[i];
    end
  end

  assign w_accept     = (r_state == ST_SEL) && !bus.uart_rts && w_sel_valid;
  assign w_stall      = (r_state == ST_SEL) && r_locked && !w_sel_valid && !bus.uart_rts;
  assign w_expire     = w_stall && (r_wdog == WDOG_LAST);
  assign w_after_byte = r_locked ? ST_SEL : ST_IDLE;

  // Next-state decode for the transmit sequencer.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (|bus.req_valid) begin
          w_state_nxt = ST_SEL;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_SEL: begin
        if (w_accept) begin
          w_state_nxt = ST_START;
        end else if (!r_locked && !w_sel_valid) begin
          w_state_nxt = ST_IDLE;
        end else if (w_expire) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_SEL;
        end
      end
      ST_START: w_state_nxt = ST_ARM;
      ST_ARM: begin
        // A UART that never raises is_trans is assumed done after two cycles.
        if (bus.is_trans || r_arm_cnt) begin
          w_state_nxt = ST_BUSY;
        end else begin
          w_state_nxt = ST_ARM;
        end
      end
      ST_BUSY: begin
        if (!bus.is_trans) begin
          w_state_nxt = (GAP_CYCLES > 0) ? ST_GAP : w_after_byte;
        end else begin
          w_state_nxt = ST_BUSY;
        end
      end
      ST_GAP: begin
        if (r_gap_cnt == GAP_ONE) begin
          w_state_nxt = w_after_byte;
        end else begin
          w_state_nxt = ST_GAP;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // State register plus registered busy flag.
  always_ff @(posedge clk_i) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_busy  <= (w_state_nxt != ST_IDLE);
    end
  end

  // Datapath: byte capture, grant/lock tracking, pulses, watchdog and pacing counters.
  always_ff @(posedge clk_i) begin
    if (rst) begin
      r_sel         <= GRANT_RST;
      r_grant_idx   <= GRANT_RST;
      r_locked      <= 1'b0;
      r_tx_byte     <= 8'h00;
      r_transmit    <= 1'b0;
      r_timeout_err <= 1'b0;
      r_arm_cnt     <= 1'b0;
      r_wdog        <= 17'd0;
      r_gap_cnt     <= '0;
    end else begin
      r_transmit    <= 1'b0;
      r_timeout_err <= 1'b0;
      case (r_state)
        ST_IDLE: r_sel <= w_pick;
        ST_SEL: begin
          if (w_accept) begin
            r_tx_byte   <= w_sel_data;
            r_grant_idx <= r_sel;
            r_locked    <= ~w_sel_last;
            r_wdog      <= 17'd0;
            r_transmit  <= 1'b1;
          end else if (w_expire) begin
            r_locked      <= 1'b0;
            r_timeout_err <= 1'b1;
            r_wdog        <= 17'd0;
          end else if (w_stall) begin
            r_wdog <= r_wdog + 17'd1;
          end
        end
        ST_START: r_arm_cnt <= 1'b0;
        ST_ARM:   r_arm_cnt <= 1'b1;
        ST_BUSY: begin
          if (!bus.is_trans) begin
            r_gap_cnt <= GAP_LOAD;
          end
        end
        ST_GAP: begin
          if (r_gap_cnt != '0) begin
            r_gap_cnt <= r_gap_cnt - GAP_ONE;
          end
        end
        default: r_arm_cnt <= 1'b0;
      endcase
    end
  end

  assign bus.req_ready = w_ready;
  assign bus.transmit  = r_transmit;
  assign bus.tx_byte   = r_tx_byte;
  assign grant_idx     = r_grant_idx;
  assign locked        = r_locked;
  assign busy          = r_busy;
  assign timeout_err   = r_timeout_err;

endmodule

// File: tb/tb_hid_uart_tx_sched.sv
// Directed bench for hid_uart_tx_sched: dut_a (GAP 0, TIMEOUT 16) and dut_b (GAP 5).
module tb_hid_uart_tx_sched;

  logic clk;
  logic rst;
  int   n_vec;
  int   n_err;

  hid_uart_tx_sched_if #(.NREQ(2)) ifa ();
  hid_uart_tx_sched_if #(.NREQ(2)) ifb ();

  logic [2:0] a_grant, b_grant;
  logic       a_locked, b_locked, a_busy, b_busy, a_to, b_to;

  hid_uart_tx_sched #(.NREQ(2), .GAP_CYCLES(0), .TIMEOUT(16)) dut_a (
    .clk_i(clk), .rst(rst), .bus(ifa),
    .grant_idx(a_grant), .locked(a_locked), .busy(a_busy), .timeout_err(a_to)
  );

  hid_uart_tx_sched #(.NREQ(2), .GAP_CYCLES(5), .TIMEOUT(16)) dut_b (
    .clk_i(clk), .rst(rst), .bus(ifb),
    .grant_idx(b_grant), .locked(b_locked), .busy(b_busy), .timeout_err(b_to)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // UART models: is_trans high for 4 cycles starting the cycle after transmit.
  logic [2:0] ua_cnt, ub_cnt;
  always @(posedge clk) begin
    if (rst)                 ua_cnt <= 3'd0;
    else if (ua_cnt != 3'd0) ua_cnt <= ua_cnt - 3'd1;
    else if (ifa.transmit)   ua_cnt <= 3'd4;
  end
  always @(posedge clk) begin
    if (rst)                 ub_cnt <= 3'd0;
    else if (ub_cnt != 3'd0) ub_cnt <= ub_cnt - 3'd1;
    else if (ifb.transmit)   ub_cnt <= 3'd4;
  end
  assign ifa.is_trans = (ua_cnt != 3'd0);
  assign ifb.is_trans = (ub_cnt != 3'd0);

  // Record every byte started on dut_a.
  typedef struct packed { logic [7:0] d; logic [2:0] g; logic l; } rec_t;
  rec_t qa[$];
  always @(negedge clk) begin
    if (!rst && ifa.transmit) qa.push_back(rec_t'{ifa.tx_byte, a_grant, a_locked});
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    ifa.req_valid = 2'b00; ifa.req_data = 16'h0000; ifa.req_last = 2'b00; ifa.uart_rts = 1'b0;
    ifb.req_valid = 2'b00; ifb.req_data = 16'h0000; ifb.req_last = 2'b00; ifb.uart_rts = 1'b0;
    repeat (3) @(negedge clk);
    qa.delete();
  endtask

  task automatic wait_q(input int n, input string tag);
    int k = 0;
    while (qa.size() < n && k < 100) begin @(negedge clk); k++; end
    chk(tag, 32'(qa.size() >= n), 32'd1);
  endtask

  task automatic wait_a_trans(input logic lvl, input string tag);
    int k = 0;
    while (ifa.is_trans !== lvl && k < 40) begin @(negedge clk); k++; end
    chk(tag, 32'(k < 40), 32'd1);
  endtask

  task automatic wait_b_trans(input logic lvl, input string tag);
    int k = 0;
    while (ifb.is_trans !== lvl && k < 40) begin @(negedge clk); k++; end
    chk(tag, 32'(k < 40), 32'd1);
  endtask

  // Present one byte on dut_a requester 0 and return the cycle after it is accepted.
  task automatic accept0(input logic [7:0] d, input logic l);
    int k = 0;
    ifa.req_data[7:0] = d;
    ifa.req_last[0]   = l;
    ifa.req_valid[0]  = 1'b1;
    #1;
    while (ifa.req_ready[0] !== 1'b1 && k < 60) begin @(negedge clk); #1; k++; end
    chk("accept0_wait", 32'(k < 60), 32'd1);
    @(negedge clk);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_ready"},  32'(ifa.req_ready), 32'd0);
    chk({tag, "_tx"},     32'(ifa.transmit),  32'd0);
    chk({tag, "_byte"},   32'(ifa.tx_byte),   32'd0);
    chk({tag, "_grant"},  32'(a_grant),       32'd1);
    chk({tag, "_locked"}, 32'(a_locked),      32'd0);
    chk({tag, "_busy"},   32'(a_busy),        32'd0);
    chk({tag, "_tmo"},    32'(a_to),          32'd0);
  endtask

  int n_to, k_to, q_at_to, lat;
  logic lk_at_to;

  initial begin
    n_vec = 0;
    n_err = 0;

    // Reset values.
    do_reset();
    chk_reset_vals("rst");
    chk("rst_b_grant", 32'(b_grant), 32'd1);

    // 1: two single-byte requesters alternate, req0 first.
    do_reset();
    ifa.req_data = 16'h4241; ifa.req_last = 2'b11; ifa.req_valid = 2'b11;
    rst = 1'b0;
    wait_q(4, "t1_wait");
    chk("t1_b0", 32'(qa[0].d), 32'h41); chk("t1_g0", 32'(qa[0].g), 32'd0);
    chk("t1_b1", 32'(qa[1].d), 32'h42); chk("t1_g1", 32'(qa[1].g), 32'd1);
    chk("t1_b2", 32'(qa[2].d), 32'h41); chk("t1_g2", 32'(qa[2].g), 32'd0);
    chk("t1_b3", 32'(qa[3].d), 32'h42);

    // 2: req0 three-byte packet holds the lock while req1 waits.
    do_reset();
    ifa.req_data[15:8] = 8'h20; ifa.req_last[1] = 1'b1; ifa.req_valid[1] = 1'b1;
    rst = 1'b0;
    accept0(8'h10, 1'b0);
    accept0(8'h11, 1'b0);
    accept0(8'h12, 1'b1);
    ifa.req_valid[0] = 1'b0;
    wait_q(4, "t2_wait");
    chk("t2_b0", 32'(qa[0].d), 32'h10); chk("t2_l0", 32'(qa[0].l), 32'd1);
    chk("t2_b1", 32'(qa[1].d), 32'h11); chk("t2_l1", 32'(qa[1].l), 32'd1);
    chk("t2_b2", 32'(qa[2].d), 32'h12); chk("t2_l2", 32'(qa[2].l), 32'd0);
    chk("t2_g2", 32'(qa[2].g), 32'd0);
    chk("t2_b3", 32'(qa[3].d), 32'h20); chk("t2_g3", 32'(qa[3].g), 32'd1);

    // 3: uart_rts holds the byte back; release gives ready now, transmit next cycle.
    do_reset();
    ifa.uart_rts = 1'b1;
    ifa.req_data[7:0] = 8'h55; ifa.req_last[0] = 1'b1; ifa.req_valid[0] = 1'b1;
    rst = 1'b0;
    repeat (6) @(negedge clk);
    chk("t3_ready_held", 32'(ifa.req_ready), 32'd0);
    chk("t3_no_tx",      32'(qa.size()),     32'd0);
    chk("t3_busy",       32'(a_busy),        32'd1);
    ifa.uart_rts = 1'b0;
    #1;
    chk("t3_ready", 32'(ifa.req_ready), 32'd1);
    chk("t3_tx_lo", 32'(ifa.transmit),  32'd0);
    @(negedge clk);
    ifa.req_valid[0] = 1'b0;
    chk("t3_tx_hi", 32'(ifa.transmit), 32'd1);
    chk("t3_byte",  32'(ifa.tx_byte),  32'h55);
    @(negedge clk);
    chk("t3_tx_one", 32'(ifa.transmit), 32'd0);

    // 4: locked requester goes silent; watchdog drops the lock and req1 gets in.
    do_reset();
    ifa.req_data[15:8] = 8'h77; ifa.req_last[1] = 1'b1; ifa.req_valid[1] = 1'b1;
    rst = 1'b0;
    accept0(8'h30, 1'b0);
    ifa.req_valid[0] = 1'b0;
    n_to = 0; k_to = 0; q_at_to = 0; lk_at_to = 1'b1;
    for (int k = 1; k <= 50; k++) begin
      @(negedge clk);
      if (a_to === 1'b1) begin
        n_to++; k_to = k; q_at_to = qa.size(); lk_at_to = a_locked;
      end
    end
    // Byte ends cycle T+6, SEL from T+7, 16 silent cycles -> pulse in T+23 = 22 cycles after T+1.
    chk("t4_pulses",   32'(n_to),     32'd1);
    chk("t4_when",     32'(k_to),     32'd22);
    chk("t4_unlocked", 32'(lk_at_to), 32'd0);
    chk("t4_q_before", 32'(q_at_to),  32'd1);
    chk("t4_b1",       32'(qa[1].d),  32'h77);
    chk("t4_g1",       32'(qa[1].g),  32'd1);

    // 5: idle cycles from is_trans fall to next ready: 1 completion cycle + GAP_CYCLES.
    do_reset();
    ifa.req_data[7:0] = 8'h01; ifa.req_valid[0] = 1'b1;
    ifb.req_data[7:0] = 8'h01; ifb.req_valid[0] = 1'b1;
    rst = 1'b0;
    wait_a_trans(1'b1, "t5a_rise");
    wait_a_trans(1'b0, "t5a_fall");
    lat = 0;
    while (ifa.req_ready[0] !== 1'b1 && lat < 30) begin lat++; @(negedge clk); end
    chk("t5_gap0_idle", 32'(lat), 32'd1);
    wait_b_trans(1'b1, "t5b_rise");
    wait_b_trans(1'b0, "t5b_fall");
    lat = 0;
    while (ifb.req_ready[0] !== 1'b1 && lat < 30) begin lat++; @(negedge clk); end
    chk("t5_gap5_idle", 32'(lat), 32'd6);

    // 6: reset while the UART is busy aborts the byte; req0 wins again afterwards.
    do_reset();
    ifa.req_data = 16'h6766; ifa.req_last = 2'b11; ifa.req_valid = 2'b11;
    rst = 1'b0;
    wait_q(2, "t6_pre");
    wait_a_trans(1'b1, "t6_rise");
    @(negedge clk);
    chk("t6_busy", 32'(a_busy), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    chk_reset_vals("t6");
    qa.delete();
    rst = 1'b0;
    wait_q(1, "t6_wait");
    chk("t6_b0", 32'(qa[0].d), 32'h66);
    chk("t6_g0", 32'(qa[0].g), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
